adc_frame_assembler: RTL and testbench

- Sits between the CS5343 ADC stream interface and the audio mixer.
- Accepts the interleaved 24-bit left/right sample stream, where last=1 marks the right sample, and assembles stereo frames.
- Emits one registered frame plus a single-cycle fs strobe per complete frame.
- Also tracks signed min/max ADC amplitude, counts frames, and flags stream framing faults and stalls for the register slave.

---
 rtl/dafx_pkg.sv | 12 +
 rtl/adc_min_max_tracker.sv | 52 +++++
 rtl/adc_frame_assembler.sv | 189 ++++++++++++++++++
 tb/tb_adc_frame_assembler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dafx_pkg.sv
// Shared types and defaults for the ADC frame assembler and its amplitude tracker.
package dafx_pkg;

    localparam int AUDIO_WIDTH_C        = 24;
    localparam int ADC_TIMEOUT_CYCLES_C = 4096;

    typedef enum logic {
        WAIT_LEFT  = 1'b0,
        WAIT_RIGHT = 1'b1
    } adc_frame_state_t;

endpackage

// File: rtl/adc_min_max_tracker.sv
// Signed running min/max over two samples per update strobe; result visible the cycle after the strobe.
// Clear has priority over a coincident update, so that update is dropped. No backpressure.
module adc_min_max_tracker
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P = AUDIO_WIDTH_C
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_update,
    input  logic                     i_clear,
    input  logic [AUDIO_WIDTH_P-1:0] i_sample_a,
    input  logic [AUDIO_WIDTH_P-1:0] i_sample_b,
    output logic [AUDIO_WIDTH_P-1:0] o_min,
    output logic [AUDIO_WIDTH_P-1:0] o_max
);

    logic signed [AUDIO_WIDTH_P-1:0] r_min;
    logic signed [AUDIO_WIDTH_P-1:0] r_max;
    logic signed [AUDIO_WIDTH_P-1:0] w_hi_ab;
    logic signed [AUDIO_WIDTH_P-1:0] w_lo_ab;
    logic signed [AUDIO_WIDTH_P-1:0] w_max_nxt;
    logic signed [AUDIO_WIDTH_P-1:0] w_min_nxt;

    always_comb begin
        w_hi_ab = $signed(i_sample_a);
        w_lo_ab = $signed(i_sample_b);
        if ($signed(i_sample_b) > $signed(i_sample_a)) begin
            w_hi_ab = $signed(i_sample_b);
            w_lo_ab = $signed(i_sample_a);
        end
        w_max_nxt = (w_hi_ab > r_max) ? w_hi_ab : r_max;
        w_min_nxt = (w_lo_ab < r_min) ? w_lo_ab : r_min;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min <= '0;
            r_max <= '0;
        end else if (i_clear) begin
            r_min <= '0;
            r_max <= '0;
        end else if (i_update) begin
            r_min <= w_min_nxt;
            r_max <= w_max_nxt;
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/adc_frame_assembler.sv
// Pairs interleaved left/right ADC beats into stereo frames; fs_strobe 1 cycle after the right beat; never backpressures.
// Optional mono sum output enabled by defining ADC_FRAME_MONO_SUM_EN (tied to 0 otherwise).
module adc_frame_assembler
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P    = AUDIO_WIDTH_C,
    parameter int TIMEOUT_CYCLES_P = ADC_TIMEOUT_CYCLES_C,
    parameter int CNT_WIDTH_P      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AUDIO_WIDTH_P-1:0] adc_data,
    input  logic                     adc_valid,
    output logic                     adc_ready,
    input  logic                     adc_last,
    output logic [AUDIO_WIDTH_P-1:0] frame_left,
    output logic [AUDIO_WIDTH_P-1:0] frame_right,
    output logic [AUDIO_WIDTH_P-1:0] frame_mono,
    output logic                     fs_strobe,
    input  logic                     cmd_clear_min_max,
    input  logic                     cmd_clear_status,
    output logic [AUDIO_WIDTH_P-1:0] sr_min_adc_amplitude,
    output logic [AUDIO_WIDTH_P-1:0] sr_max_adc_amplitude,
    output logic [CNT_WIDTH_P-1:0]   sr_frame_count,
    output logic                     sr_sync_error,
    output logic                     sr_timeout
);

    localparam int TMO_W = (TIMEOUT_CYCLES_P > 1) ? $clog2(TIMEOUT_CYCLES_P) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES_P - 1);

    adc_frame_state_t         r_state;
    adc_frame_state_t         w_state_nxt;
    logic [TMO_W-1:0]         r_tmo_cnt;
    logic [TMO_W-1:0]         w_tmo_cnt_nxt;
    logic                     r_ready;
    logic [AUDIO_WIDTH_P-1:0] r_hold_left;
    logic                     r_pend_vld;
    logic [AUDIO_WIDTH_P-1:0] r_pend_left;
    logic [AUDIO_WIDTH_P-1:0] r_pend_right;
    logic [AUDIO_WIDTH_P-1:0] r_frame_left;
    logic [AUDIO_WIDTH_P-1:0] r_frame_right;
    logic                     r_fs;
    logic [CNT_WIDTH_P-1:0]   r_frame_count;
    logic                     r_sync_err;
    logic                     r_tmo_flag;

    logic w_accept;
    logic w_load_left;
    logic w_frame_done;
    logic w_sync_ev;
    logic w_tmo_ev;

    assign w_accept = adc_valid & r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= WAIT_LEFT;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    // An accepted beat is evaluated before the timeout, so a beat on the expiry cycle wins.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_load_left   = 1'b0;
        w_frame_done  = 1'b0;
        w_sync_ev     = 1'b0;
        w_tmo_ev      = 1'b0;
        unique case (r_state)
            WAIT_LEFT: begin
                w_tmo_cnt_nxt = '0;
                if (w_accept) begin
                    if (adc_last) begin
                        w_sync_ev = 1'b1;
                    end else begin
                        w_load_left = 1'b1;
                        w_state_nxt = WAIT_RIGHT;
                    end
                end
            end
            WAIT_RIGHT: begin
                if (w_accept) begin
                    if (adc_last) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = WAIT_LEFT;
                    end else begin
                        w_sync_ev     = 1'b1;
                        w_load_left   = 1'b1;
                        w_tmo_cnt_nxt = '0;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_ev      = 1'b1;
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = WAIT_LEFT;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            default: begin
                w_state_nxt   = WAIT_LEFT;
                w_tmo_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready       <= 1'b0;
            r_hold_left   <= '0;
            r_pend_vld    <= 1'b0;
            r_pend_left   <= '0;
            r_pend_right  <= '0;
            r_frame_left  <= '0;
            r_frame_right <= '0;
            r_fs          <= 1'b0;
            r_frame_count <= '0;
            r_sync_err    <= 1'b0;
            r_tmo_flag    <= 1'b0;
        end else begin
            r_ready    <= 1'b1;
            r_pend_vld <= w_frame_done;
            r_fs       <= r_pend_vld;
            if (w_load_left) begin
                r_hold_left <= adc_data;
            end
            if (w_frame_done) begin
                r_pend_left  <= r_hold_left;
                r_pend_right <= adc_data;
            end
            if (r_pend_vld) begin
                r_frame_left  <= r_pend_left;
                r_frame_right <= r_pend_right;
                r_frame_count <= r_frame_count + CNT_WIDTH_P'(1);
            end
            r_sync_err <= w_sync_ev | (r_sync_err & ~cmd_clear_status);
            r_tmo_flag <= w_tmo_ev  | (r_tmo_flag & ~cmd_clear_status);
        end
    end

`ifdef ADC_FRAME_MONO_SUM_EN
    logic signed [AUDIO_WIDTH_P:0] w_mono_sum;
    logic [AUDIO_WIDTH_P-1:0]      r_frame_mono;

    // One guard bit keeps the sum exact; halving brings it back into sample range.
    always_comb begin
        w_mono_sum = ($signed({r_pend_left[AUDIO_WIDTH_P-1], r_pend_left})
                    + $signed({r_pend_right[AUDIO_WIDTH_P-1], r_pend_right})) >>> 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_mono <= '0;
        end else if (r_pend_vld) begin
            r_frame_mono <= w_mono_sum[AUDIO_WIDTH_P-1:0];
        end
    end

    assign frame_mono = r_frame_mono;
`else
    assign frame_mono = '0;
`endif

    adc_min_max_tracker #(
        .AUDIO_WIDTH_P (AUDIO_WIDTH_P)
    ) u_min_max (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_update   (r_fs),
        .i_clear    (cmd_clear_min_max),
        .i_sample_a (r_frame_left),
        .i_sample_b (r_frame_right),
        .o_min      (sr_min_adc_amplitude),
        .o_max      (sr_max_adc_amplitude)
    );

    assign adc_ready      = r_ready;
    assign frame_left     = r_frame_left;
    assign frame_right    = r_frame_right;
    assign fs_strobe      = r_fs;
    assign sr_frame_count = r_frame_count;
    assign sr_sync_error  = r_sync_err;
    assign sr_timeout     = r_tmo_flag;

endmodule

// File: tb/tb_adc_frame_assembler.sv
// Randomized and directed stimulus for adc_frame_assembler, scored against a transaction-level reference model.
module tb_adc_frame_assembler;

    localparam int W  = 24;
    localparam int TO = 20;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          adc_ready;
    logic          adc_last = 1'b0;
    logic [W-1:0]  frame_left;
    logic [W-1:0]  frame_right;
    logic [W-1:0]  frame_mono;
    logic          fs_strobe;
    logic          cmd_clear_min_max = 1'b0;
    logic          cmd_clear_status = 1'b0;
    logic [W-1:0]  sr_min_adc_amplitude;
    logic [W-1:0]  sr_max_adc_amplitude;
    logic [CW-1:0] sr_frame_count;
    logic          sr_sync_error;
    logic          sr_timeout;

    adc_frame_assembler #(
        .AUDIO_WIDTH_P    (W),
        .TIMEOUT_CYCLES_P (TO),
        .CNT_WIDTH_P      (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .adc_data             (adc_data),
        .adc_valid            (adc_valid),
        .adc_ready            (adc_ready),
        .adc_last             (adc_last),
        .frame_left           (frame_left),
        .frame_right          (frame_right),
        .frame_mono           (frame_mono),
        .fs_strobe            (fs_strobe),
        .cmd_clear_min_max    (cmd_clear_min_max),
        .cmd_clear_status     (cmd_clear_status),
        .sr_min_adc_amplitude (sr_min_adc_amplitude),
        .sr_max_adc_amplitude (sr_max_adc_amplitude),
        .sr_frame_count       (sr_frame_count),
        .sr_sync_error        (sr_sync_error),
        .sr_timeout           (sr_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: a held left sample waiting for its partner, a count of idle
    // cycles spent waiting, and a one-deep queue of frames awaiting publication.
    bit          m_ready;
    bit          m_have_left;
    int          m_held;
    int          m_idle;
    bit          m_pend;
    int          m_pend_l;
    int          m_pend_r;
    bit          m_fs;
    int          m_fl;
    int          m_fr;
    int          m_mono;
    int          m_cnt;
    int          m_min;
    int          m_max;
    bit          m_sync;
    bit          m_tmo;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_edge(input logic rst, input logic v, input logic l, input logic [W-1:0] d,
                              input logic cmm, input logic cst);
        bit acc;
        bit sync_ev;
        bit tmo_ev;
        if (!rst) begin
            m_ready = 0; m_have_left = 0; m_held = 0; m_idle = 0; m_pend = 0;
            m_pend_l = 0; m_pend_r = 0; m_fs = 0; m_fl = 0; m_fr = 0; m_mono = 0;
            m_cnt = 0; m_min = 0; m_max = 0; m_sync = 0; m_tmo = 0;
            return;
        end
        if (cmm) begin
            m_min = 0;
            m_max = 0;
        end else if (m_fs) begin
            if (m_fl > m_max) m_max = m_fl;
            if (m_fr > m_max) m_max = m_fr;
            if (m_fl < m_min) m_min = m_fl;
            if (m_fr < m_min) m_min = m_fr;
        end
        m_fs = m_pend;
        if (m_pend) begin
            m_fl  = m_pend_l;
            m_fr  = m_pend_r;
`ifdef ADC_FRAME_MONO_SUM_EN
            m_mono = (m_pend_l + m_pend_r) >>> 1;
`else
            m_mono = 0;
`endif
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
        m_pend  = 0;
        acc     = v && m_ready;
        m_ready = 1;
        sync_ev = 0;
        tmo_ev  = 0;
        if (acc && l) begin
            if (m_have_left) begin
                m_pend = 1; m_pend_l = m_held; m_pend_r = sx(d); m_have_left = 0;
            end else begin
                sync_ev = 1;
            end
        end else if (acc) begin
            if (m_have_left) sync_ev = 1;
            m_held = sx(d); m_have_left = 1; m_idle = 0;
        end else if (m_have_left) begin
            m_idle++;
            if (m_idle == TO) begin
                tmo_ev = 1; m_have_left = 0;
            end
        end
        m_sync = sync_ev || (m_sync && !cst);
        m_tmo  = tmo_ev  || (m_tmo  && !cst);
    endtask

    task automatic compare_all();
        check_val("adc_ready",   32'(adc_ready),   32'(m_ready));
        check_val("fs_strobe",   32'(fs_strobe),   32'(m_fs));
        check_val("frame_left",  32'(frame_left),  32'(m_fl[W-1:0]));
        check_val("frame_right", 32'(frame_right), 32'(m_fr[W-1:0]));
        check_val("frame_mono",  32'(frame_mono),  32'(m_mono[W-1:0]));
        check_val("frame_count", 32'(sr_frame_count), 32'(m_cnt[CW-1:0]));
        check_val("min_amp",     32'(sr_min_adc_amplitude), 32'(m_min[W-1:0]));
        check_val("max_amp",     32'(sr_max_adc_amplitude), 32'(m_max[W-1:0]));
        check_val("sync_error",  32'(sr_sync_error), 32'(m_sync));
        check_val("timeout",     32'(sr_timeout),    32'(m_tmo));
    endtask

    task automatic cyc(input logic v, input logic l, input logic [W-1:0] d,
                       input logic cmm = 1'b0, input logic cst = 1'b0);
        adc_valid = v; adc_last = l; adc_data = d;
        cmd_clear_min_max = cmm; cmd_clear_status = cst;
        @(posedge clk);
        model_edge(rst_n, v, l, d, cmm, cst);
        #1;
        compare_all();
        adc_valid = 1'b0; adc_last = 1'b0;
        cmd_clear_min_max = 1'b0; cmd_clear_status = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r);
        cyc(1'b1, 1'b0, l);
        cyc(1'b1, 1'b1, r);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        check_val("rst_ready", 32'(adc_ready), 32'd0);
        check_val("rst_count", 32'(sr_frame_count), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check_val("ready_rise", 32'(adc_ready), 32'd1);

        // Normal stream
        frame(24'h000100, 24'hFFFF00);
        idle(1);
        check_val("tp_fs",    32'(fs_strobe),   32'd1);
        check_val("tp_left",  32'(frame_left),  32'h000100);
        check_val("tp_right", 32'(frame_right), 32'hFFFF00);
        check_val("tp_count", 32'(sr_frame_count), 32'd1);
        idle(1);
        check_val("tp_fs_off", 32'(fs_strobe), 32'd0);
        check_val("tp_max",    32'(sr_max_adc_amplitude), 32'h000100);
        check_val("tp_min",    32'(sr_min_adc_amplitude), 32'hFFFF00);

        // Orphan right, plus clear-status colliding with a fresh error
        do_reset();
        cyc(1'b1, 1'b1, 24'h123456);
        frame(24'd5, 24'd7);
        idle(2);
        check_val("orph_sync",  32'(sr_sync_error), 32'd1);
        check_val("orph_left",  32'(frame_left),  32'd5);
        check_val("orph_right", 32'(frame_right), 32'd7);
        check_val("orph_count", 32'(sr_frame_count), 32'd1);
        cyc(1'b1, 1'b1, 24'h000001, 1'b0, 1'b1);
        check_val("clr_collide_sync", 32'(sr_sync_error), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_val("clr_sync", 32'(sr_sync_error), 32'd0);

        // Timeout, then a fresh pair must not reuse the abandoned left
        do_reset();
        cyc(1'b1, 1'b0, 24'd9);
        idle(TO);
        check_val("tmo_flag",  32'(sr_timeout), 32'd1);
        check_val("tmo_count", 32'(sr_frame_count), 32'd0);
        frame(24'd1, 24'd2);
        idle(1);
        check_val("tmo_left",  32'(frame_left),  32'd1);
        check_val("tmo_right", 32'(frame_right), 32'd2);

        // Right beat on the expiry cycle wins over the timeout
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 24'h00AAAA);
        idle(TO - 1);
        cyc(1'b1, 1'b1, 24'h00BBBB);
        idle(1);
        check_val("edge_tmo",   32'(sr_timeout), 32'd0);
        check_val("edge_left",  32'(frame_left), 32'h00AAAA);
        check_val("edge_right", 32'(frame_right), 32'h00BBBB);

        // Min/max clear colliding with the tracker update
        do_reset();
        frame(24'h7FFFFF, 24'h800000);
        idle(1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        check_val("clr_max", 32'(sr_max_adc_amplitude), 32'd0);
        check_val("clr_min", 32'(sr_min_adc_amplitude), 32'd0);
        frame(24'd3, 24'hFFFFFC);
        idle(2);
        check_val("post_max", 32'(sr_max_adc_amplitude), 32'd3);
        check_val("post_min", 32'(sr_min_adc_amplitude), 32'hFFFFFC);

        // Frame counter wrap at 2^CW
        do_reset();
        for (int i = 0; i < 15; i++) frame(24'(i), 24'(i + 100));
        idle(1);
        check_val("count_15", 32'(sr_frame_count), 32'd15);
        frame(24'd1, 24'd1);
        idle(1);
        check_val("count_wrap", 32'(sr_frame_count), 32'd0);

        // Mono sum extremes
        frame(24'h7FFFFF, 24'h7FFFFF);
        idle(1);
`ifdef ADC_FRAME_MONO_SUM_EN
        check_val("mono_max", 32'(frame_mono), 32'h7FFFFF);
`else
        check_val("mono_off", 32'(frame_mono), 32'd0);
`endif
        frame(24'hFFFFFD, 24'd0);
        idle(1);
`ifdef ADC_FRAME_MONO_SUM_EN
        check_val("mono_neg", 32'(frame_mono), 32'hFFFFFE);
`else
        check_val("mono_off2", 32'(frame_mono), 32'd0);
`endif

        // Reset mid-frame drops the held left
        cyc(1'b1, 1'b0, 24'd77);
        do_reset();
        cyc(1'b1, 1'b1, 24'd78);
        idle(2);
        check_val("midrst_count", 32'(sr_frame_count), 32'd0);
        check_val("midrst_sync",  32'(sr_sync_error), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic v;
            logic l;
            logic [W-1:0] d;
            r = $urandom_range(0, 999);
            if (r < 5) begin
                do_reset();
            end else if (r < 12) begin
                cyc(1'b1, 1'b0, 24'($urandom));
                idle($urandom_range(TO - 2, TO + 2));
            end else begin
                v = ($urandom_range(0, 99) < 55);
                if (m_have_left) l = ($urandom_range(0, 9) != 0);
                else             l = ($urandom_range(0, 9) == 0);
                case ($urandom_range(0, 7))
                    0:       d = 24'h7FFFFF;
                    1:       d = 24'h800000;
                    default: d = 24'($urandom);
                endcase
                cyc(v, l, d, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
